mem_responder: RTL and testbench

//   Memory-side responder for the multicycle core's memory port; the core is the initiator.

---
 rtl/mem_responder.sv | 167 ++++++++++++++++
 tb/tb_mem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multicycle core's memory port. This block
//   models the unified instruction/data memory. It accepts one request at a
//   time, inserts WAIT_CYCLES wait states, and then returns a response.
//
// Parameters
//   WIDTH        data word width in bits
//   DEPTH        number of WIDTH-bit words (power of two, >= 2)
//   WAIT_CYCLES  wait states between accept and response (0..255)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset)
//   req_valid  initiator presents a request
//   req_ready  responder can accept a request (IDLE only)
//   req_we     1 = write, 0 = read
//   req_addr   byte address
//   req_wdata  write data
//   rsp_valid  response available
//   rsp_ready  initiator accepts the response this cycle
//   rsp_rdata  read data (0 for writes and errors)
//   rsp_err    misaligned or out-of-range access
module mem_responder #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
    localparam logic [7:0]  CNT_INIT   = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       cnt_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [WIDTH-1:0] wdata_q;

    logic             accept;
    logic             commit;
    logic             rsp_done;

    logic             c_we;
    logic [31:0]      c_addr;
    logic [WIDTH-1:0] c_wdata;
    logic             c_err;
    logic [AW-1:0]    c_idx;

    logic [WIDTH-1:0] mem [DEPTH];

    // With zero wait states, the commit happens on the accept edge itself.
    // In that case the live request inputs feed the commit, not the latched copies.
    always_comb begin
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end
        c_err = (c_addr[1:0] != 2'b00) || (c_addr >= ADDR_LIMIT);
        c_idx = c_addr[AW+1:2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // req_ready is gated by reset so that it reads 0 while reset is held.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        commit    = 1'b0;
        rsp_done  = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = reset;
                if (req_valid && reset) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d  = S_IDLE;
                    rsp_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt_q   <= CNT_INIT;
            end else if (state_q == S_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 8'd1;
            end

            if (commit) begin
                rsp_err   <= c_err;
                rsp_rdata <= (c_err || c_we) ? '0 : mem[c_idx];
            end else if (rsp_done) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // The array is deliberately not reset. A pending write is dropped on reset
    // because commit can only fire from a live, non-reset state.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            mem[c_idx] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        tgt;  // 0 = two-wait-state instance, 1 = zero-wait-state instance

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;

    assign a_req_valid = req_valid & ~tgt;
    assign b_req_valid = req_valid &  tgt;
    assign a_rsp_ready = rsp_ready & ~tgt;
    assign b_rsp_ready = rsp_ready &  tgt;
    assign m_req_ready = tgt ? b_req_ready : a_req_ready;
    assign m_rsp_valid = tgt ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_rdata = tgt ? b_rsp_rdata : a_rsp_rdata;
    assign m_rsp_err   = tgt ? b_rsp_err   : a_rsp_err;

    mem_responder #(.WIDTH(32), .DEPTH(64), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    mem_responder #(.WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    int acc_cnt = 0;
    always @(posedge clk) begin
        if (a_req_valid && a_req_ready) acc_cnt++;
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Called at a negedge. Runs one full request/response transaction on the selected instance.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int n;
        int lat;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        n = 0;
        while (m_req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":accept"}, 32'(n < 20), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (m_rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), tgt ? 32'd1 : 32'd3);
        check({tag, ":rdata"}, m_rsp_rdata, exp_rd);
        check({tag, ":err"}, 32'(m_rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ":valid_clr"}, 32'(m_rsp_valid), 32'd0);
        check({tag, ":rdata_clr"}, m_rsp_rdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        int  acc0;
        logic stable;

        tgt       = 1'b0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // 1: reset state
        repeat (3) @(negedge clk);
        check("t1:ready_in_rst", 32'(a_req_ready), 32'd0);
        check("t1:valid_in_rst", 32'(a_rsp_valid), 32'd0);
        check("t1:rdata_in_rst", a_rsp_rdata, 32'd0);
        check("t1:err_in_rst", 32'(a_rsp_err), 32'd0);
        reset = 1'b1;
        #1;
        check("t1:ready_after", 32'(a_req_ready), 32'd1);
        @(negedge clk);

        // 2: write then read back
        txn(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "t2:wr");
        txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "t2:rd");

        // 3: error cases; word 0 must survive the out-of-range write
        txn(1'b1, 32'h0, 32'h0BADF00D, 32'h0, 1'b0, "t3:wr0");
        txn(1'b0, 32'h0102, 32'h0, 32'h0, 1'b1, "t3:misalign");
        txn(1'b1, 32'h100, 32'h11111111, 32'h0, 1'b1, "t3:oor_wr");
        txn(1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, "t3:rd0");
        txn(1'b1, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0, "t3:wr_last");
        txn(1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0, "t3:rd_last");
        txn(1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, "t3:oor_rd_hi");

        // 4: response back-pressure with req_valid held high
        acc0      = acc_cnt;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (a_rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4:rsp_seen", 32'(n < 20), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADBEEF || a_req_ready !== 1'b0)
                stable = 1'b0;
            @(negedge clk);
        end
        check("t4:stable", 32'(stable), 32'd1);
        check("t4:one_accept", 32'(acc_cnt - acc0), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t4:no_accept_at_hs", 32'(acc_cnt - acc0), 32'd1);
        check("t4:valid_clr", 32'(a_rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("t4:second_accept", 32'(acc_cnt - acc0), 32'd2);
        n = 0;
        while (a_rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4:second_rdata", a_rsp_rdata, 32'hDEADBEEF);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // 5: zero-wait-state instance
        tgt = 1'b1;
        txn(1'b1, 32'h04, 32'h12345678, 32'h0, 1'b0, "t5:wr");
        txn(1'b0, 32'h04, 32'h0, 32'h12345678, 1'b0, "t5:rd");
        txn(1'b0, 32'h06, 32'h0, 32'h0, 1'b1, "t5:misalign");
        tgt = 1'b0;
        @(negedge clk);

        // 6: reset during WAIT drops the pending write
        txn(1'b1, 32'h08, 32'hAAAA0008, 32'h0, 1'b0, "t6:wr_old");
        req_we    = 1'b1;
        req_addr  = 32'h08;
        req_wdata = 32'h55;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("t6:accepted", 32'(a_req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("t6:ready_in_rst", 32'(a_req_ready), 32'd0);
        check("t6:valid_in_rst", 32'(a_rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6:ready_after", 32'(a_req_ready), 32'd1);
        @(negedge clk);
        txn(1'b0, 32'h08, 32'h0, 32'hAAAA0008, 1'b0, "t6:rd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
